period_meter: RTL

- Zero-crossing period estimator on the 10-bit offset-binary ADC sample stream (midscale 512).
- Sits directly downstream of the adc capture wrapper, in parallel with la_filter and phase_adjust.
- Hysteresis comparator detects rising crossings and counts valid samples between accepted crossings.
- Averages 2^AVG_LOG2 periods and reports the period, a lock flag and a no-signal timeout; phase_adjust and b_rescue consume the result for frequency-aware phase stepping.

---
 rtl/period_meter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/period_meter.sv
// Zero-crossing period estimator for an offset-binary ADC sample stream.
// A hysteresis comparator squares the input. Valid samples are counted between
// accepted rising crossings. 2^AVG_LOG2 periods are averaged into one result.
// The block also reports a stable-frequency lock flag and a no-signal timeout.
module period_meter #(
    parameter int DATA_W          = 10,
    parameter int MID             = 512,
    parameter int HYST            = 16,
    parameter int CNT_W           = 20,
    parameter int AVG_LOG2        = 2,
    parameter int MIN_PERIOD      = 8,
    parameter int LOCK_TOL        = 2,
    parameter int TIMEOUT_SAMPLES = 1000000
) (
    input  logic              clk,
    input  logic              sys_rst,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] input_signal,
    output logic [CNT_W-1:0]  o_period,
    output logic              o_period_valid,
    output logic              o_locked,
    output logic              o_timeout,
    output logic              o_cross
);

    localparam int ACC_W = CNT_W + AVG_LOG2;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MEAS = 1'b1;

    // Thresholds are one bit wider than the sample, so MID+HYST cannot wrap.
    localparam logic [DATA_W:0]   HI_TH    = (DATA_W+1)'(MID + HYST);
    localparam logic [DATA_W:0]   LO_TH    = (DATA_W+1)'(MID - HYST);
    localparam logic [CNT_W-1:0]  MIN_P    = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0]  TOL      = CNT_W'(LOCK_TOL);
    localparam logic [CNT_W-1:0]  TMO      = CNT_W'(TIMEOUT_SAMPLES);
    localparam logic [AVG_LOG2-1:0] N_LAST = AVG_LOG2'((2 ** AVG_LOG2) - 1);

    logic [0:0]          state_reg, state_next;
    logic                sq_reg, sq_level;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [ACC_W-1:0]    acc_reg, acc_next;
    logic [AVG_LOG2-1:0] n_reg, n_next;
    logic [CNT_W-1:0]    period_reg, period_next;
    logic                pvalid_reg, pvalid_next;
    logic                locked_reg, locked_next;
    logic                timeout_reg, timeout_next;
    logic                cross_reg, cross_next;
    // Set once a result exists to compare against; the first result after IDLE never locks.
    logic                have_prev_reg, have_prev_next;

    logic [DATA_W:0]     sample_ext;
    logic                crossing;
    logic [CNT_W-1:0]    p_cand;
    logic [ACC_W-1:0]    acc_sum;
    logic [CNT_W-1:0]    avg;
    logic [CNT_W-1:0]    diff;

    assign sample_ext = {1'b0, input_signal};
    assign p_cand     = cnt_reg + 1'b1;
    assign acc_sum    = acc_reg + {{AVG_LOG2{1'b0}}, p_cand};
    assign avg        = acc_sum[ACC_W-1:AVG_LOG2];
    assign diff       = (avg >= period_reg) ? (avg - period_reg) : (period_reg - avg);
    assign crossing   = i_valid && !sq_reg && sq_level;

    // Hysteresis comparator: the level the comparator takes on this sample.
    always_comb begin
        sq_level = sq_reg;
        if (sample_ext >= HI_TH) begin
            sq_level = 1'b1;
        end else if (sample_ext <= LO_TH) begin
            sq_level = 1'b0;
        end
    end

    // Measurement FSM: counting, averaging, lock and timeout decisions.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        acc_next       = acc_reg;
        n_next         = n_reg;
        period_next    = period_reg;
        pvalid_next    = 1'b0;
        locked_next    = locked_reg;
        timeout_next   = timeout_reg;
        cross_next     = 1'b0;
        have_prev_next = have_prev_reg;
        if (i_valid) begin
            case (state_reg)
                ST_IDLE: begin
                    if (crossing) begin
                        cnt_next     = '0;
                        cross_next   = 1'b1;
                        timeout_next = 1'b0;
                        state_next   = ST_MEAS;
                    end
                end
                default: begin
                    if (crossing && (p_cand >= MIN_P)) begin
                        // An accepted crossing beats a timeout on the same sample.
                        cnt_next   = '0;
                        cross_next = 1'b1;
                        if (n_reg != N_LAST) begin
                            acc_next = acc_sum;
                            n_next   = n_reg + 1'b1;
                        end else begin
                            period_next    = avg;
                            pvalid_next    = 1'b1;
                            acc_next       = '0;
                            n_next         = '0;
                            locked_next    = have_prev_reg && (diff <= TOL);
                            have_prev_next = 1'b1;
                        end
                    end else if (crossing) begin
                        // Glitch: too close to the last crossing, treat as an ordinary sample.
                        cnt_next = p_cand;
                    end else if (p_cand == TMO) begin
                        timeout_next   = 1'b1;
                        locked_next    = 1'b0;
                        period_next    = '0;
                        acc_next       = '0;
                        n_next         = '0;
                        cnt_next       = '0;
                        have_prev_next = 1'b0;
                        state_next     = ST_IDLE;
                    end else begin
                        cnt_next = p_cand;
                    end
                end
            endcase
        end
    end

    // State registers with synchronous reset; the comparator advances only on valid samples.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_reg     <= ST_IDLE;
            sq_reg        <= 1'b0;
            cnt_reg       <= '0;
            acc_reg       <= '0;
            n_reg         <= '0;
            period_reg    <= '0;
            pvalid_reg    <= 1'b0;
            locked_reg    <= 1'b0;
            timeout_reg   <= 1'b0;
            cross_reg     <= 1'b0;
            have_prev_reg <= 1'b0;
        end else begin
            if (i_valid) begin
                sq_reg <= sq_level;
            end
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            acc_reg       <= acc_next;
            n_reg         <= n_next;
            period_reg    <= period_next;
            pvalid_reg    <= pvalid_next;
            locked_reg    <= locked_next;
            timeout_reg   <= timeout_next;
            cross_reg     <= cross_next;
            have_prev_reg <= have_prev_next;
        end
    end

    assign o_period       = period_reg;
    assign o_period_valid = pvalid_reg;
    assign o_locked       = locked_reg;
    assign o_timeout      = timeout_reg;
    assign o_cross        = cross_reg;

endmodule
